// File: rtl/ifq_rom_ctrl_if.sv
// ifq_rom_ctrl_if: bundle of the icache miss/fill handshake, flush/full status
// and boot ROM read port used by ifq_rom_ctrl.
//   master : requester side (icache + ROM model); drives alloc, flush, ROM data
//   slave  : ifq_rom_ctrl; drives full, ROM read strobe/address, fill outputs
interface ifq_rom_ctrl_if #(
    parameter int unsigned OPTN_ADDR_WIDTH     = 32,
    parameter int unsigned OPTN_IC_LINE_SIZE   = 32,
    parameter int unsigned OPTN_ROM_DATA_WIDTH = 32,
    parameter int unsigned OPTN_HEX_SIZE       = 2048
);
    localparam int unsigned IC_LINE_WIDTH  = OPTN_IC_LINE_SIZE * 8;
    localparam int unsigned ROM_ADDR_WIDTH = (OPTN_HEX_SIZE > 1) ? $clog2(OPTN_HEX_SIZE) : 1;

    logic                           i_flush;
    logic                           o_full;
    logic                           i_alloc_en;
    logic [OPTN_ADDR_WIDTH-1:0]     i_alloc_addr;
    logic                           o_rom_en;
    logic [ROM_ADDR_WIDTH-1:0]      o_rom_addr;
    logic [OPTN_ROM_DATA_WIDTH-1:0] i_rom_data;
    logic                           o_fill_en;
    logic [OPTN_ADDR_WIDTH-1:0]     o_fill_addr;
    logic [IC_LINE_WIDTH-1:0]       o_fill_data;

    modport master (
        output i_flush, i_alloc_en, i_alloc_addr, i_rom_data,
        input  o_full, o_rom_en, o_rom_addr, o_fill_en, o_fill_addr, o_fill_data
    );

    modport slave (
        input  i_flush, i_alloc_en, i_alloc_addr, i_rom_data,
        output o_full, o_rom_en, o_rom_addr, o_fill_en, o_fill_addr, o_fill_data
    );
endinterface

// File: rtl/ifq_rom_ctrl.sv
// ifq_rom_ctrl: queued icache miss sequencer in front of a narrow synchronous
// boot ROM. Misses are queued as line addresses; the head line is read one ROM
// beat per cycle, assembled in a line buffer and returned as one fill pulse.
// Ports:
//   clk, n_rst : clock, asynchronous active-low reset
//   bus        : ifq_rom_ctrl_if.slave (flush, full, alloc, ROM port, fill)
// Optional feature: define PROCYON_IFQ_DEDUP_EN to drop allocs whose line is
// already held in the queue (including the line currently being filled).
module ifq_rom_ctrl #(
    parameter int unsigned OPTN_ADDR_WIDTH     = 32,
    parameter int unsigned OPTN_IC_LINE_SIZE   = 32,
    parameter int unsigned OPTN_ROM_DATA_WIDTH = 32,
    parameter int unsigned OPTN_HEX_SIZE       = 2048,
    parameter int unsigned OPTN_IFQ_DEPTH      = 4
) (
    input  logic          clk,
    input  logic          n_rst,
    ifq_rom_ctrl_if.slave bus
);
    localparam int unsigned IC_LINE_WIDTH  = OPTN_IC_LINE_SIZE * 8;
    localparam int unsigned BEATS          = IC_LINE_WIDTH / OPTN_ROM_DATA_WIDTH;
    localparam int unsigned ROM_ADDR_WIDTH = (OPTN_HEX_SIZE > 1) ? $clog2(OPTN_HEX_SIZE) : 1;
    localparam int unsigned OFF_W          = $clog2(OPTN_IC_LINE_SIZE);
    localparam int unsigned LA_W           = OPTN_ADDR_WIDTH - OFF_W;
    localparam int unsigned BEAT_W         = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned PTR_W          = $clog2(OPTN_IFQ_DEPTH);
    localparam int unsigned CNT_W          = PTR_W + 1;
    localparam int unsigned SUM_W          = LA_W + BEAT_W;

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_FILL} state_e;

    state_e                     state_q, state_d;
    logic [BEAT_W-1:0]          beat_q, beat_d;
    logic [PTR_W-1:0]           head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]           count_q, count_d;
    logic [LA_W-1:0]            q_mem_q [OPTN_IFQ_DEPTH];
    logic [LA_W-1:0]            q_mem_d [OPTN_IFQ_DEPTH];
    logic [IC_LINE_WIDTH-1:0]   linebuf_q, linebuf_d;
    logic                       rd_pend_q, rd_pend_d;
    logic [BEAT_W-1:0]          rd_beat_q, rd_beat_d;
    logic                       rom_en_q, rom_en_d;
    logic [ROM_ADDR_WIDTH-1:0]  rom_addr_q, rom_addr_d;
    logic                       fill_en_q, fill_en_d;
    logic [OPTN_ADDR_WIDTH-1:0] fill_addr_q, fill_addr_d;
    logic [IC_LINE_WIDTH-1:0]   fill_data_q, fill_data_d;

    logic [LA_W-1:0]            alloc_line_c;
    logic [LA_W-1:0]            next_head_line_c;
    logic [CNT_W-1:0]           cnt_after_pop_c;
    logic                       full_c;
    logic                       dup_c;
    logic                       alloc_acc_c;
    logic                       pop_c;
    logic                       unused_offset;

    // ROM beat index = line * BEATS + beat, truncated to the ROM address width
    function automatic logic [ROM_ADDR_WIDTH-1:0] rom_beat_addr(
        input logic [LA_W-1:0]   line,
        input logic [BEAT_W-1:0] beat
    );
        logic [SUM_W-1:0] idx;
        idx = SUM_W'(line) * SUM_W'(BEATS) + SUM_W'(beat);
        return ROM_ADDR_WIDTH'(idx);
    endfunction

    assign full_c        = (count_q == CNT_W'(OPTN_IFQ_DEPTH));
    assign unused_offset = ^bus.i_alloc_addr[OFF_W-1:0];

    // Next-state / next-output logic
    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        q_mem_d     = q_mem_q;
        linebuf_d   = linebuf_q;
        rd_pend_d   = rom_en_q;
        rd_beat_d   = beat_q;
        rom_en_d    = 1'b0;
        rom_addr_d  = rom_addr_q;
        fill_en_d   = 1'b0;
        fill_addr_d = fill_addr_q;
        fill_data_d = fill_data_q;
        pop_c       = 1'b0;
        dup_c       = 1'b0;

        alloc_line_c = bus.i_alloc_addr[OPTN_ADDR_WIDTH-1:OFF_W];

`ifdef PROCYON_IFQ_DEDUP_EN
        // Entry i is valid when its distance from head is below count
        for (int unsigned i = 0; i < OPTN_IFQ_DEPTH; i++) begin
            if ((CNT_W'(PTR_W'(PTR_W'(i) - head_q)) < count_q) && (q_mem_q[i] == alloc_line_c))
                dup_c = 1'b1;
        end
`endif

        alloc_acc_c = bus.i_alloc_en & ~full_c & ~bus.i_flush & ~dup_c;

        // ROM data lands the cycle after its strobe
        if (rd_pend_q)
            linebuf_d[32'(rd_beat_q) * OPTN_ROM_DATA_WIDTH +: OPTN_ROM_DATA_WIDTH] = bus.i_rom_data;

        // With one entry left, a same-cycle alloc becomes the next head
        next_head_line_c = (count_q == CNT_W'(1)) ? alloc_line_c : q_mem_q[PTR_W'(head_q + PTR_W'(1))];
        cnt_after_pop_c  = CNT_W'(count_q - CNT_W'(1) + CNT_W'(alloc_acc_c));

        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    state_d    = S_READ;
                    beat_d     = '0;
                    rom_en_d   = 1'b1;
                    rom_addr_d = rom_beat_addr(q_mem_q[head_q], BEAT_W'(0));
                end
            end
            S_READ: begin
                if (beat_q == BEAT_W'(BEATS - 1)) begin
                    state_d = S_DRAIN;
                end else begin
                    beat_d     = BEAT_W'(beat_q + BEAT_W'(1));
                    rom_en_d   = 1'b1;
                    rom_addr_d = rom_beat_addr(q_mem_q[head_q], BEAT_W'(beat_q + BEAT_W'(1)));
                end
            end
            S_DRAIN: begin
                state_d     = S_FILL;
                fill_en_d   = 1'b1;
                fill_addr_d = {q_mem_q[head_q], OFF_W'(0)};
                fill_data_d = linebuf_d;
            end
            S_FILL: begin
                pop_c = 1'b1;
                if (cnt_after_pop_c != '0) begin
                    state_d    = S_READ;
                    beat_d     = '0;
                    rom_en_d   = 1'b1;
                    rom_addr_d = rom_beat_addr(next_head_line_c, BEAT_W'(0));
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (alloc_acc_c) begin
            q_mem_d[tail_q] = alloc_line_c;
            tail_d          = PTR_W'(tail_q + PTR_W'(1));
        end
        if (pop_c)
            head_d = PTR_W'(head_q + PTR_W'(1));
        count_d = CNT_W'(count_q + CNT_W'(alloc_acc_c) - CNT_W'(pop_c));

        // Flush discards everything; an already-registered fill still shows this cycle
        if (bus.i_flush) begin
            state_d   = S_IDLE;
            beat_d    = '0;
            head_d    = '0;
            tail_d    = '0;
            count_d   = '0;
            rd_pend_d = 1'b0;
            rom_en_d  = 1'b0;
            fill_en_d = 1'b0;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= S_IDLE;
            beat_q      <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            for (int unsigned i = 0; i < OPTN_IFQ_DEPTH; i++)
                q_mem_q[i] <= '0;
            linebuf_q   <= '0;
            rd_pend_q   <= 1'b0;
            rd_beat_q   <= '0;
            rom_en_q    <= 1'b0;
            rom_addr_q  <= '0;
            fill_en_q   <= 1'b0;
            fill_addr_q <= '0;
            fill_data_q <= '0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            q_mem_q     <= q_mem_d;
            linebuf_q   <= linebuf_d;
            rd_pend_q   <= rd_pend_d;
            rd_beat_q   <= rd_beat_d;
            rom_en_q    <= rom_en_d;
            rom_addr_q  <= rom_addr_d;
            fill_en_q   <= fill_en_d;
            fill_addr_q <= fill_addr_d;
            fill_data_q <= fill_data_d;
        end
    end

    assign bus.o_full      = full_c;
    assign bus.o_rom_en    = rom_en_q;
    assign bus.o_rom_addr  = rom_addr_q;
    assign bus.o_fill_en   = fill_en_q;
    assign bus.o_fill_addr = fill_addr_q;
    assign bus.o_fill_data = fill_data_q;
endmodule
